// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding and load-use stall detection for a 5-stage pipeline.
// Shadows the destination info of the EX, MEM and WB stages to steer operand muxes.
module forward_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic                  ex_valid, ex_use_rs1, ex_use_rs2, ex_reg_write, ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic                  mem_valid, mem_reg_write, mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic mem_wr_ok, wb_wr_ok;
    logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
    logic ex_load_ok;

    always_comb begin
        mem_wr_ok  = mem_valid && mem_reg_write && (mem_rd != '0);
        wb_wr_ok   = wb_valid && wb_reg_write && (wb_rd != '0);
        mem_hit_a  = ex_valid && ex_use_rs1 && mem_wr_ok && (mem_rd == ex_rs1);
        wb_hit_a   = ex_valid && ex_use_rs1 && wb_wr_ok && (wb_rd == ex_rs1);
        mem_hit_b  = ex_valid && ex_use_rs2 && mem_wr_ok && (mem_rd == ex_rs2);
        wb_hit_b   = ex_valid && ex_use_rs2 && wb_wr_ok && (wb_rd == ex_rs2);
        ex_load_ok = ex_valid && ex_mem_read && ex_reg_write && (ex_rd != '0);
    end

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_hit_a) begin
            fwd_a = 2'b01;
        end else if (wb_hit_a) begin
            fwd_a = 2'b10;
        end
        if (mem_hit_b) begin
            fwd_b = 2'b01;
        end else if (wb_hit_b) begin
            fwd_b = 2'b10;
        end
    end

    always_comb begin
        stall = id_valid && ex_load_ok &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_use_rs1    <= 1'b0;
            ex_use_rs2    <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            stall_count   <= '0;
        end else begin
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            if (stall || flush) begin
                ex_valid     <= 1'b0;
                ex_rs1       <= '0;
                ex_rs2       <= '0;
                ex_use_rs1   <= 1'b0;
                ex_use_rs2   <= 1'b0;
                ex_rd        <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_rs1       <= id_rs1;
                ex_rs2       <= id_rs2;
                ex_use_rs1   <= id_use_rs1;
                ex_use_rs2   <= id_use_rs2;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

    // Load data is not ready in MEM; the load-use stall must keep this from happening.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((mem_hit_a || mem_hit_b) && mem_mem_read));
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed and randomized checks of forward_hazard_unit against an instruction-history model.
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [1:0] fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic       stall, stall_s;
    logic [15:0] stall_count;
    logic [1:0]  stall_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forward_hazard_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
    );

    forward_hazard_unit #(.CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall(stall_s), .stall_count(stall_count_s)
    );

    // Instruction history: hist[0] is in EX, hist[1] in MEM, hist[2] in WB.
    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, rw, mr;
    } instr_t;

    instr_t hist [3];
    int     m_cnt;
    int     m_cnt_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input bit [4:0] r, input bit used);
        if (!hist[0].v || !used) return 2'b00;
        for (int d = 1; d <= 2; d++) begin
            if (hist[d].v && hist[d].rw && hist[d].rd != 0 && hist[d].rd == r)
                return (d == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        instr_t e;
        e = hist[0];
        if (!id_valid || !e.v || !e.mr || !e.rw || e.rd == 0) return 1'b0;
        return (id_use_rs1 && id_rs1 == e.rd) || (id_use_rs2 && id_rs2 == e.rd);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic drive(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                         input bit u2, input bit [4:0] rd, input bit rw, input bit mr,
                         input bit fl);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
        #2;
        check("fwd_a", 32'(fwd_a), 32'(m_fwd(hist[0].rs1, hist[0].u1)));
        check("fwd_b", 32'(fwd_b), 32'(m_fwd(hist[0].rs2, hist[0].u2)));
        check("stall", 32'(stall), 32'(m_stall()));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        check("stall_count_small", 32'(stall_count_s), 32'(m_cnt_s));
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        bit s;
        instr_t n;
        s = m_stall();
        n = '{v: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd, u1: id_use_rs1,
              u2: id_use_rs2, rw: id_reg_write, mr: id_mem_read};
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else begin
            if (s) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (s || flush) ? '{default: 0} : n;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        nop();
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_cnt", 32'(stall_count), 0);

        // ALU back-to-back dependency
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 6, 1, 8, 1, 0, 0); tick();
        nop();
        check("alu_fwd_a", 32'(fwd_a), 32'h1);

        // Distance-2 dependency, then MEM beats WB
        drive(1, 1, 1, 2, 1, 7, 1, 0, 0); tick();
        drive(1, 1, 1, 2, 1, 8, 1, 0, 0); tick();
        drive(1, 1, 0, 7, 1, 9, 1, 0, 0); tick();
        nop();
        check("dist2_fwd_b", 32'(fwd_b), 32'h2);
        tick();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 0); tick();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 0); tick();
        drive(1, 1, 0, 7, 1, 9, 1, 0, 0); tick();
        nop();
        check("prio_fwd_b", 32'(fwd_b), 32'h1);
        tick();

        // Load-use: one stall, then forward from WB
        do_reset();
        drive(1, 1, 1, 2, 0, 3, 1, 1, 0); tick();
        drive(1, 3, 1, 2, 0, 10, 1, 0, 0);
        check("lu_stall", 32'(stall), 1);
        tick();
        drive(1, 3, 1, 2, 0, 10, 1, 0, 0);
        check("lu_no_restall", 32'(stall), 0);
        check("lu_cnt", 32'(stall_count), 1);
        tick();
        nop();
        check("lu_fwd_a", 32'(fwd_a), 32'h2);
        tick(); tick();

        // x0 never forwarded; unused operand never stalls
        drive(1, 1, 1, 2, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 1, 2, 0, 11, 1, 0, 0); tick();
        nop();
        check("x0_fwd_a", 32'(fwd_a), 0);
        tick();
        drive(1, 1, 0, 2, 0, 4, 1, 1, 0); tick();
        drive(1, 1, 0, 4, 0, 12, 1, 0, 0);
        check("unused_stall", 32'(stall), 0);
        tick(); tick(); tick();

        // Flush squashes producer; flush with stall yields one bubble
        drive(1, 1, 1, 2, 1, 9, 1, 0, 1); tick();
        drive(1, 9, 1, 2, 0, 13, 1, 0, 0); tick();
        nop();
        check("flush_fwd_a", 32'(fwd_a), 0);
        tick(); tick();
        drive(1, 1, 0, 2, 0, 3, 1, 1, 0); tick();
        drive(1, 3, 1, 2, 0, 14, 1, 0, 1);
        check("fs_stall", 32'(stall), 1);
        tick();
        nop();
        check("fs_bubble_stall", 32'(stall), 0);
        tick(); tick();

        // Reset mid-flight
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 5, 1, 5, 1, 1, 0); tick();
        rst = 1'b1;
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0); tick();
        rst = 1'b0;
        nop();
        check("mid_rst_fwd_a", 32'(fwd_a), 0);
        check("mid_rst_fwd_b", 32'(fwd_b), 0);
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_cnt", 32'(stall_count), 0);

        // Five stalls saturate the 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 2, 0, 3, 1, 1, 0); tick();
            drive(1, 3, 1, 2, 0, 15, 1, 0, 1); tick();
        end
        nop();
        check("sat_small", 32'(stall_count_s), 3);
        check("sat_big", 32'(stall_count), 5);

        // Randomized traffic on a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0));
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
